// File: rtl/reservation_entry_gen.sv
// Single reservation-station entry: captures an op with its source operands and
// snoops the CDB until every source is present, then holds it for issue.
module reservation_entry_gen #(
    parameter int unsigned P_DATA_W = 32,
    parameter int unsigned P_REG_W  = 6,
    parameter int unsigned P_SRC_N  = 2,
    parameter int unsigned P_CDB_N  = 3,
    parameter int unsigned P_PAY_W  = 48,
    parameter int unsigned P_TAG_W  = 6,
    parameter int unsigned P_AGE_W  = 4
) (
    input  logic                          iCLOCK,
    input  logic                          inRESET,
    input  logic                          iFLUSH,
    input  logic                          iKILL_VALID,
    input  logic [P_TAG_W-1:0]            iKILL_TAG,
    input  logic                          iREGISTER_VALID,
    input  logic [P_PAY_W-1:0]            iREGISTER_PAYLOAD,
    input  logic [P_TAG_W-1:0]            iREGISTER_TAG,
    input  logic [P_SRC_N-1:0]            iREGISTER_SRC_VALID,
    input  logic [P_SRC_N*P_DATA_W-1:0]   iREGISTER_SRC,
    input  logic [P_CDB_N-1:0]            iCDB_VALID,
    input  logic [P_CDB_N-1:0]            iCDB_WB,
    input  logic [P_CDB_N*P_REG_W-1:0]    iCDB_REGNAME,
    input  logic [P_CDB_N*P_DATA_W-1:0]   iCDB_DATA,
    input  logic                          iISSUE_GRANT,
    output logic                          oINFO_ENTRY_VALID,
    output logic                          oINFO_REGIST_LOCK,
    output logic                          oINFO_READY,
    output logic [P_AGE_W-1:0]            oINFO_AGE,
    output logic [P_PAY_W-1:0]            oINFO_PAYLOAD,
    output logic [P_TAG_W-1:0]            oINFO_TAG,
    output logic [P_SRC_N-1:0]            oINFO_SRC_VALID,
    output logic [P_SRC_N*P_DATA_W-1:0]   oINFO_SRC
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [P_PAY_W-1:0]            payload_q, payload_d;
    logic [P_TAG_W-1:0]            tag_q, tag_d;
    logic [P_SRC_N-1:0]            src_valid_q, src_valid_d;
    logic [P_SRC_N*P_DATA_W-1:0]   src_q, src_d;
    logic [P_AGE_W-1:0]            age_q, age_d;
    logic                          removed_q, removed_d;

    logic [P_SRC_N-1:0]            hit;
    logic [P_DATA_W-1:0]           hit_data [P_SRC_N];
    logic [P_REG_W-1:0]            src_name [P_SRC_N];
    logic                          occupied;
    logic                          kill_hit;

    assign occupied = (state_q != EMPTY);
    assign kill_hit = iKILL_VALID && occupied && (iKILL_TAG == tag_q);

    // Source names come from the incoming op while empty, otherwise from storage;
    // the lowest-index matching CDB channel wins.
    always_comb begin
        hit = '0;
        for (int unsigned s = 0; s < P_SRC_N; s++) begin
            hit_data[s] = '0;
            src_name[s] = (state_q == EMPTY) ? iREGISTER_SRC[s*P_DATA_W +: P_REG_W]
                                             : src_q[s*P_DATA_W +: P_REG_W];
            for (int unsigned c = 0; c < P_CDB_N; c++) begin
                if (!hit[s] && iCDB_VALID[c] && iCDB_WB[c] &&
                    (iCDB_REGNAME[c*P_REG_W +: P_REG_W] == src_name[s])) begin
                    hit[s]      = 1'b1;
                    hit_data[s] = iCDB_DATA[c*P_DATA_W +: P_DATA_W];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        payload_d   = payload_q;
        tag_d       = tag_q;
        src_valid_d = src_valid_q;
        src_d       = src_q;
        age_d       = age_q;
        removed_d   = 1'b0;

        if (iFLUSH || kill_hit || (iISSUE_GRANT && state_q == READY)) begin
            state_d     = EMPTY;
            payload_d   = '0;
            tag_d       = '0;
            src_valid_d = '0;
            src_d       = '0;
            age_d       = '0;
            removed_d   = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (iREGISTER_VALID) begin
                        payload_d = iREGISTER_PAYLOAD;
                        tag_d     = iREGISTER_TAG;
                        age_d     = '0;
                        for (int unsigned s = 0; s < P_SRC_N; s++) begin
                            if (iREGISTER_SRC_VALID[s]) begin
                                src_valid_d[s]                   = 1'b1;
                                src_d[s*P_DATA_W +: P_DATA_W]    = iREGISTER_SRC[s*P_DATA_W +: P_DATA_W];
                            end else if (hit[s]) begin
                                src_valid_d[s]                   = 1'b1;
                                src_d[s*P_DATA_W +: P_DATA_W]    = hit_data[s];
                            end else begin
                                src_valid_d[s]                   = 1'b0;
                                src_d[s*P_DATA_W +: P_DATA_W]    = P_DATA_W'(src_name[s]);
                            end
                        end
                        state_d = (&src_valid_d) ? READY : WAIT;
                    end
                end
                WAIT: begin
                    for (int unsigned s = 0; s < P_SRC_N; s++) begin
                        if (!src_valid_q[s] && hit[s]) begin
                            src_valid_d[s]                = 1'b1;
                            src_d[s*P_DATA_W +: P_DATA_W] = hit_data[s];
                        end
                    end
                    state_d = (&src_valid_d) ? READY : WAIT;
                    if (age_q != '1) age_d = age_q + P_AGE_W'(1);
                end
                READY: begin
                    if (age_q != '1) age_d = age_q + P_AGE_W'(1);
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q     <= EMPTY;
            payload_q   <= '0;
            tag_q       <= '0;
            src_valid_q <= '0;
            src_q       <= '0;
            age_q       <= '0;
            removed_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            payload_q   <= payload_d;
            tag_q       <= tag_d;
            src_valid_q <= src_valid_d;
            src_q       <= src_d;
            age_q       <= age_d;
            removed_q   <= removed_d;
        end
    end

    // Lock also covers the single cycle after a removal so a stale grant cannot re-register.
    assign oINFO_ENTRY_VALID = occupied;
    assign oINFO_REGIST_LOCK = occupied | removed_q;
    assign oINFO_READY       = (state_q == READY);
    assign oINFO_AGE         = age_q;
    assign oINFO_PAYLOAD     = payload_q;
    assign oINFO_TAG         = tag_q;
    assign oINFO_SRC_VALID   = src_valid_q;
    assign oINFO_SRC         = src_q;

endmodule

// File: tb/tb_reservation_entry_gen.sv
// Bench for reservation_entry_gen: directed scenarios plus randomized traffic
// checked against an operand-level reference model.
module tb_reservation_entry_gen;

    logic        iCLOCK = 1'b0;
    logic        inRESET;
    logic        flush, kill_v, reg_v, grant;
    logic [5:0]  kill_tag, rtag;
    logic [47:0] pay;
    logic [1:0]  rsv;
    logic [63:0] rsrc;
    logic [2:0]  cv, cwb;
    logic [17:0] cname;
    logic [95:0] cdata;

    logic        ev, lock, rdy;
    logic [1:0]  age;
    logic [47:0] opay;
    logic [5:0]  otag;
    logic [1:0]  osv;
    logic [63:0] osrc;

    int total = 0;
    int bad   = 0;

    reservation_entry_gen #(.P_AGE_W(2)) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iFLUSH(flush),
        .iKILL_VALID(kill_v), .iKILL_TAG(kill_tag),
        .iREGISTER_VALID(reg_v), .iREGISTER_PAYLOAD(pay), .iREGISTER_TAG(rtag),
        .iREGISTER_SRC_VALID(rsv), .iREGISTER_SRC(rsrc),
        .iCDB_VALID(cv), .iCDB_WB(cwb), .iCDB_REGNAME(cname), .iCDB_DATA(cdata),
        .iISSUE_GRANT(grant),
        .oINFO_ENTRY_VALID(ev), .oINFO_REGIST_LOCK(lock), .oINFO_READY(rdy),
        .oINFO_AGE(age), .oINFO_PAYLOAD(opay), .oINFO_TAG(otag),
        .oINFO_SRC_VALID(osv), .oINFO_SRC(osrc)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic idle();
        flush = 0; kill_v = 0; kill_tag = '0; reg_v = 0; grant = 0;
        pay = '0; rtag = '0; rsv = '0; rsrc = '0;
        cv = '0; cwb = '0; cname = '0; cdata = '0;
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++; if ({ev, lock, rdy, age} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b want 00000", {ev, lock, rdy, age}); end
        total++; if ({opay, otag, osv} !== 56'b0) begin bad++; $display("FAIL reset_fields: got %h want 0", {opay, otag, osv}); end
        total++; if (osrc !== 64'b0) begin bad++; $display("FAIL reset_src: got %h want 0", osrc); end
        @(negedge iCLOCK);
        inRESET = 1;
    endtask

    task automatic test_wait_cdb();
        reg_v = 1; pay = 48'hABCDEF012345; rtag = 6'h07; rsv = 2'b01;
        rsrc = {32'hFFFF_FF05, 32'h0000_1234};
        tick();
        idle();
        total++; if ({ev, rdy, lock} !== 3'b101) begin bad++; $display("FAIL wait_state: got %b want 101", {ev, rdy, lock}); end
        total++; if (osv !== 2'b01) begin bad++; $display("FAIL wait_srcv: got %b want 01", osv); end
        total++; if (osrc !== {32'h5, 32'h1234}) begin bad++; $display("FAIL wait_src: got %h want %h", osrc, {32'h5, 32'h1234}); end
        total++; if ({opay, otag} !== {48'hABCDEF012345, 6'h07}) begin bad++; $display("FAIL wait_payload: got %h want %h", {opay, otag}, {48'hABCDEF012345, 6'h07}); end
        cv = 3'b010; cwb = 3'b010; cname = {6'd0, 6'd5, 6'd0}; cdata = {32'h0, 32'hDEAD, 32'h0};
        tick();
        idle();
        total++; if (osrc[63:32] !== 32'hDEAD) begin bad++; $display("FAIL cdb_capture: got %h want dead", osrc[63:32]); end
        total++; if ({rdy, osv} !== 3'b111) begin bad++; $display("FAIL cdb_ready: got %b want 111", {rdy, osv}); end
    endtask

    task automatic test_grant_flush();
        grant = 1; flush = 1;
        tick();
        idle();
        total++; if ({ev, rdy, lock} !== 3'b001) begin bad++; $display("FAIL gf_state: got %b want 001", {ev, rdy, lock}); end
        total++; if ({opay, otag, osv, osrc, age} !== '0) begin bad++; $display("FAIL gf_fields: got %h want 0", {opay, otag, osv, osrc}); end
        tick();
        total++; if (lock !== 1'b0) begin bad++; $display("FAIL gf_lock_drop: got %b want 0", lock); end
        reg_v = 1; rsv = 2'b11; rsrc = {32'h2, 32'h1}; rtag = 6'h3;
        tick();
        idle();
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL g_ready: got %b want 1", rdy); end
        grant = 1;
        tick();
        idle();
        total++; if ({ev, lock, opay, osrc} !== {1'b0, 1'b1, 112'b0}) begin bad++; $display("FAIL grant_only: got ev=%b lock=%b src=%h want 0 1 0", ev, lock, osrc); end
        tick();
        reg_v = 1; rsv = 2'b10; rsrc = {32'h77, 32'h14}; pay = 48'h5A5A; rtag = 6'h9;
        tick();
        idle();
        grant = 1;
        tick();
        idle();
        total++; if ({ev, rdy, opay, otag} !== {1'b1, 1'b0, 48'h5A5A, 6'h9}) begin bad++; $display("FAIL grant_in_wait: got ev=%b rdy=%b pay=%h want 1 0 5a5a", ev, rdy, opay); end
        flush = 1;
        tick();
        idle();
        tick();
    endtask

    task automatic test_cdb_priority();
        reg_v = 1; rsv = 2'b00; rsrc = {32'h3, 32'h3};
        cv = 3'b111; cwb = 3'b101; cname = {6'd3, 6'd3, 6'd3}; cdata = {32'hB, 32'hC, 32'hA};
        tick();
        idle();
        total++; if (osrc !== {32'hA, 32'hA}) begin bad++; $display("FAIL cdb_lowest: got %h want %h", osrc, {32'hA, 32'hA}); end
        total++; if ({rdy, osv} !== 3'b111) begin bad++; $display("FAIL cdb_reg_ready: got %b want 111", {rdy, osv}); end
        flush = 1;
        tick();
        idle();
        tick();
    endtask

    task automatic test_kill();
        reg_v = 1; rsv = 2'b01; rsrc = {32'h21, 32'h99}; rtag = 6'h11; pay = 48'h1;
        tick();
        idle();
        kill_v = 1; kill_tag = 6'h12;
        tick();
        idle();
        total++; if ({ev, otag, osrc} !== {1'b1, 6'h11, 32'h21, 32'h99}) begin bad++; $display("FAIL kill_nomatch: got ev=%b tag=%h want 1 11", ev, otag); end
        kill_v = 1; kill_tag = 6'h11;
        tick();
        idle();
        total++; if ({ev, lock, otag} !== {1'b0, 1'b1, 6'h0}) begin bad++; $display("FAIL kill_match: got ev=%b lock=%b tag=%h want 0 1 0", ev, lock, otag); end
        tick();
        total++; if (lock !== 1'b0) begin bad++; $display("FAIL kill_lock_drop: got %b want 0", lock); end
    endtask

    task automatic test_age();
        reg_v = 1; rsv = 2'b00; rsrc = {32'h9, 32'h9};
        tick();
        idle();
        for (int i = 0; i < 6; i++) begin
            total++; if (age !== 2'((i < 3) ? i : 3)) begin bad++; $display("FAIL age_%0d: got %0d want %0d", i, age, (i < 3) ? i : 3); end
            if (i < 5) tick();
        end
    endtask

    task automatic test_async_reset();
        #2;
        inRESET = 0;
        #1;
        total++; if ({ev, lock, rdy, age, opay, otag, osv, osrc} !== '0) begin bad++; $display("FAIL async_reset: got ev=%b lock=%b age=%0d tag=%h", ev, lock, age, otag); end
        #2;
        inRESET = 1;
        reg_v = 1; rsv = 2'b11; rsrc = {32'hCAFE, 32'hBEEF}; rtag = 6'h2A;
        tick();
        idle();
        total++; if ({ev, rdy, otag, osrc} !== {1'b1, 1'b1, 6'h2A, 32'hCAFE, 32'hBEEF}) begin bad++; $display("FAIL post_reset_reg: got ev=%b rdy=%b src=%h", ev, rdy, osrc); end
    endtask

    // Reference model: an entry is a bag of operands; it is ready when all are present.
    bit          m_occ, m_pulse;
    logic [47:0] m_pay;
    logic [5:0]  m_tag;
    bit          m_sv [2];
    logic [31:0] m_src [2];
    int          m_age;

    function automatic bit cdb_lookup(input logic [5:0] name, output logic [31:0] d);
        d = '0;
        for (int c = 0; c < 3; c++)
            if (cv[c] && cwb[c] && cname[c*6 +: 6] == name) begin
                d = cdata[c*32 +: 32];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic void model_clear();
        m_occ = 0; m_pay = '0; m_tag = '0; m_age = 0;
        for (int s = 0; s < 2; s++) begin m_sv[s] = 0; m_src[s] = '0; end
    endfunction

    function automatic void model_step();
        logic [31:0] d;
        bit all_v = m_sv[0] && m_sv[1];
        if (flush || (kill_v && m_occ && kill_tag == m_tag) || (grant && m_occ && all_v)) begin
            model_clear();
            m_pulse = 1;
        end else begin
            m_pulse = 0;
            if (m_occ) begin
                for (int s = 0; s < 2; s++)
                    if (!m_sv[s] && cdb_lookup(m_src[s][5:0], d)) begin m_sv[s] = 1; m_src[s] = d; end
                m_age = (m_age < 3) ? m_age + 1 : 3;
            end else if (reg_v) begin
                m_occ = 1; m_pay = pay; m_tag = rtag; m_age = 0;
                for (int s = 0; s < 2; s++) begin
                    if (rsv[s]) begin m_sv[s] = 1; m_src[s] = rsrc[s*32 +: 32]; end
                    else if (cdb_lookup(rsrc[s*32 +: 6], d)) begin m_sv[s] = 1; m_src[s] = d; end
                    else begin m_sv[s] = 0; m_src[s] = {26'b0, rsrc[s*32 +: 6]}; end
                end
            end
        end
    endfunction

    task automatic test_random();
        logic [31:0] v;
        idle();
        #2 inRESET = 0;
        #2 inRESET = 1;
        model_clear();
        m_pulse = 0;
        tick();
        for (int n = 0; n < 400; n++) begin
            flush    = ($urandom_range(0, 15) == 0);
            kill_v   = ($urandom_range(0, 7) == 0);
            kill_tag = ($urandom_range(0, 1) == 0) ? m_tag : 6'($urandom());
            reg_v    = $urandom_range(0, 1);
            grant    = ($urandom_range(0, 3) == 0);
            pay      = {16'($urandom()), 32'($urandom())};
            rtag     = 6'($urandom());
            rsv      = 2'($urandom());
            for (int s = 0; s < 2; s++) begin
                v = $urandom();
                v[5:0] = 6'($urandom_range(0, 7));
                rsrc[s*32 +: 32] = v;
            end
            cv  = 3'($urandom());
            cwb = 3'($urandom());
            for (int c = 0; c < 3; c++) begin
                cname[c*6 +: 6]  = 6'($urandom_range(0, 7));
                cdata[c*32 +: 32] = $urandom();
            end
            model_step();
            tick();
            total++; if ({ev, rdy} !== {m_occ, m_occ && m_sv[0] && m_sv[1]}) begin bad++; $display("FAIL rnd_state n=%0d: got %b want %b", n, {ev, rdy}, {m_occ, m_occ && m_sv[0] && m_sv[1]}); end
            total++; if (lock !== (m_occ || m_pulse)) begin bad++; $display("FAIL rnd_lock n=%0d: got %b want %b", n, lock, m_occ || m_pulse); end
            total++; if (age !== 2'(m_age)) begin bad++; $display("FAIL rnd_age n=%0d: got %0d want %0d", n, age, m_age); end
            total++; if ({opay, otag} !== {m_pay, m_tag}) begin bad++; $display("FAIL rnd_payload n=%0d: got %h want %h", n, {opay, otag}, {m_pay, m_tag}); end
            total++; if ({osv, osrc} !== {m_sv[1], m_sv[0], m_src[1], m_src[0]}) begin bad++; $display("FAIL rnd_src n=%0d: got %h want %h", n, {osv, osrc}, {m_sv[1], m_sv[0], m_src[1], m_src[0]}); end
        end
        idle();
    endtask

    initial begin
        idle();
        inRESET = 0;
        test_reset();
        test_wait_cdb();
        test_grant_flush();
        test_cdb_priority();
        test_kill();
        test_age();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reservation_entry_gen.md
RESERVATION_ENTRY_GEN -- requirements
Module: reservation_entry_gen

Interface
REQ-001 SHALL take parameter P_DATA_W, default 32: source operand data width.
REQ-002 SHALL take parameter P_REG_W, default 6: physical register name width, with P_REG_W <= P_DATA_W.
REQ-003 SHALL take parameter P_SRC_N, default 2: number of source operands, 1..4.
REQ-004 SHALL take parameter P_CDB_N, default 3: number of common data bus channels, 1..8.
REQ-005 SHALL take parameter P_PAY_W, default 48: width of an opaque payload (cmd, afe, unit selects, flags, dest, pcr).
REQ-006 SHALL take parameter P_TAG_W, default 6: commit tag width.
REQ-007 SHALL take parameter P_AGE_W, default 4: age counter width.
REQ-008 SHALL have the ports below (name, direction, width, meaning):
- iCLOCK, in, 1: clock.
- inRESET, in, 1: reset, asynchronous, active-low.
- iFLUSH, in, 1: remove the entry unconditionally.
- iKILL_VALID, in, 1: selective-kill request.
- iKILL_TAG, in, P_TAG_W: tag to kill.
- iREGISTER_VALID, in, 1: write a new op into the entry.
- iREGISTER_PAYLOAD, in, P_PAY_W: op payload.
- iREGISTER_TAG, in, P_TAG_W: commit tag.
- iREGISTER_SRC_VALID, in, P_SRC_N: per-source "value present" flags.
- iREGISTER_SRC, in, P_SRC_N*P_DATA_W: per-source value or register name; when a source is not valid its name is in bits [P_REG_W-1:0].
- iCDB_VALID, in, P_CDB_N: per-channel broadcast valid.
- iCDB_WB, in, P_CDB_N: per-channel writeback qualifier.
- iCDB_REGNAME, in, P_CDB_N*P_REG_W: per-channel destination register name.
- iCDB_DATA, in, P_CDB_N*P_DATA_W: per-channel result data.
- iISSUE_GRANT, in, 1: the scheduler takes the op.
- oINFO_ENTRY_VALID, out, 1: entry is occupied.
- oINFO_REGIST_LOCK, out, 1: entry is not available for registration.
- oINFO_READY, out, 1: all sources are valid.
- oINFO_AGE, out, P_AGE_W: cycles since registration, saturating.
- oINFO_PAYLOAD, out, P_PAY_W: stored payload.
- oINFO_TAG, out, P_TAG_W: stored commit tag.
- oINFO_SRC_VALID, out, P_SRC_N: per-source valid flags.
- oINFO_SRC, out, P_SRC_N*P_DATA_W: per-source stored value or name.

Function
REQ-009 SHALL implement states EMPTY, WAIT and READY; oINFO_ENTRY_VALID=1 in WAIT and in READY; oINFO_READY=1 only in READY.
REQ-010 SHALL treat CDB channel c as a hit for a source when iCDB_VALID[c] & iCDB_WB[c] is 1 and its regname equals the source name [P_REG_W-1:0].
- If several channels hit, the lowest index wins.
REQ-011 On iREGISTER_VALID in EMPTY, SHALL capture payload and tag, and set each source as follows:
- if its SRC_VALID bit is set: valid with the supplied value;
- else if a CDB hit exists in the same cycle: valid with the CDB data;
- else: invalid, with the value zero-extended from the name.
REQ-012 SHALL go from EMPTY to READY when every source resolves at registration, and otherwise to WAIT.
REQ-013 In WAIT, SHALL check each invalid source independently against the CDB every cycle; on a hit the source becomes valid with the data.
- The state becomes READY in the cycle after the last source resolves.
REQ-014 SHALL never modify a source that is already valid.
REQ-015 SHALL ignore iREGISTER_VALID when not in EMPTY.
REQ-016 SHALL honour iISSUE_GRANT only in READY: the next state is EMPTY and all stored fields clear to 0.
- iISSUE_GRANT in any other state is ignored.
REQ-017 SHALL remove the entry next cycle (state EMPTY, fields cleared) on either condition:
- iFLUSH=1;
- iKILL_VALID=1 with iKILL_TAG equal to the stored tag while occupied.
REQ-018 SHALL apply this priority per cycle: reset > iFLUSH > kill match > iISSUE_GRANT > registration/CDB capture.
- A kill that does not match leaves the entry unchanged.
REQ-019 SHALL drive oINFO_REGIST_LOCK as:
- 1 while occupied;
- 1 for exactly the one cycle after any removal (grant, flush, kill);
- 0 otherwise.
- Registration is accepted only when the state is EMPTY; the scheduler gates on the lock.
REQ-020 SHALL drive oINFO_AGE as:
- set to 0 on registration;
- incremented by 1 each occupied cycle, saturating at 2^P_AGE_W-1;
- 0 when EMPTY.
REQ-021 SHALL drive all outputs directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-022 On inRESET low, SHALL asynchronously force state EMPTY and drive every output to 0, including oINFO_REGIST_LOCK=0.
REQ-023 On reset mid-operation, SHALL discard the entry contents, so the first cycle after reset release accepts a registration.

Verification
REQ-024 Register with src0 valid=0x1234, src1 name 0x05 invalid, no CDB traffic -> WAIT, SRC_VALID=01, SRC1=0x5. Then CDB ch1 valid/wb, regname 5, data 0xDEAD -> next cycle SRC1=0xDEAD, READY=1.
REQ-025 Register with both sources invalid (names 3 and 3) while CDB ch0 and ch2 both hit name 3 with 0xA and 0xB in the same cycle -> both sources = 0xA, state READY after one cycle.
REQ-026 Registered entry with tag 0x11 and iKILL tag 0x12 -> no change. Then iKILL tag 0x11 -> EMPTY next cycle, LOCK=1 for one cycle, then 0.
REQ-027 READY entry with iISSUE_GRANT and iFLUSH asserted together -> EMPTY, fields 0. The same outcome follows with grant alone, and a grant applied in WAIT is ignored.
REQ-028 With P_AGE_W=2, hold the entry in WAIT for 6 cycles -> AGE sequence 0,1,2,3,3,3.
REQ-029 Assert inRESET low asynchronously mid-WAIT -> all outputs 0 immediately. Release reset and register in the next cycle -> accepted.
